wb_host_master: RTL and testbench

Wishbone classic single-transfer initiator that issues bus cycles toward the user project's Wishbone slave port from a simple valid/ready command interface. It is used on-chip as a debug/test host and in the verification environment as a reusable bus driver. Each command produces exactly one read or write cycle and exactly one response, with a programmable ack timeout.

---
 rtl/wb_host_pkg.sv | 19 +
 rtl/wb_host_timeout.sv | 30 +++
 rtl/wb_host_master.sv | 137 +++++++++++++
 tb/tb_wb_host_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and bus widths for the Wishbone single-transfer host.
package wb_host_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
  } rsp_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Ack-wait counter: cleared at command accept, counts idle bus cycles,
// flags the last allowed cycle.
module wb_host_timeout #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one command in, one bus cycle, one response out,
// with an ack timeout that turns a hung cycle into an error response.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  rsp_t                rsp_q, rsp_d;
  logic                cnt_clr, cnt_en, expire_c;

  wb_host_timeout #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .expire_c (expire_c)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  // Next-state and next register values; ack beats a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d.dat   = we_q ? '0 : wbm_dat_i;
          rsp_d.err   = 1'b0;
          state_d     = RESP;
        end else if (expire_c) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d.dat   = '0;
          rsp_d.err   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master: random commands against an in-bench
// Wishbone slave with programmable ack delay and a queue of expected responses.
module tb_wb_host_master;

  localparam int TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  wb_host_master #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          d;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  cmd_t slv_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 1;
  bit   stray_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Slave model plus protocol/response monitor, all sampled on the falling edge.
  cmd_t act;
  exp_t held, e;
  bit   busy = 0, hold_v = 0;
  int   k = 0, cyc_len = 0, exp_len;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      slv_q.delete();
      exp_q.delete();
      busy = 0; hold_v = 0; k = 0; cyc_len = 0;
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0;
    end else begin
      chk("cmd_ready", 32'(cmd_ready_o), 32'(!busy));
      chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
      if (wbm_cyc_o) begin
        if (k == 0) begin
          if (slv_q.size() == 0) begin
            fails++; tests++;
            $display("FAIL unexpected_cyc: got cyc=1, expected no cycle at %0t", $time);
            act = '{we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0, d: 1000, rdata: 32'h0};
          end else begin
            act = slv_q.pop_front();
          end
        end
        chk("wbm_we", 32'(wbm_we_o), 32'(act.we));
        chk("wbm_adr", wbm_adr_o, act.adr);
        chk("wbm_dat", wbm_dat_o, act.dat);
        chk("wbm_sel", 32'(wbm_sel_o), 32'(act.sel));
        wbm_ack_i = (k == act.d);
        wbm_dat_i = act.rdata;
        k++;
        cyc_len++;
      end else begin
        if (cyc_len > 0) begin
          exp_len = (act.d < TO) ? act.d + 1 : TO;
          chk("cyc_length", 32'(cyc_len), 32'(exp_len));
          chk("rsp_after_cyc", 32'(rsp_valid_o), 32'd1);
        end
        cyc_len = 0;
        k = 0;
        wbm_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        wbm_dat_i = $urandom;
      end
      if (hold_v) begin
        chk("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
        chk("rsp_hold_dat", rsp_dat_o, held.dat);
        chk("rsp_hold_err", 32'(rsp_err_o), 32'(held.err));
      end
      hold_v = 0;
      if (rsp_valid_o) begin
        if (rsp_ready_i) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rsp: got dat=%h err=%b, expected none at %0t",
                     rsp_dat_o, rsp_err_o, $time);
          end else begin
            tests--;
            e = exp_q.pop_front();
            chk("rsp_dat", rsp_dat_o, e.dat);
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          end
        end else begin
          hold_v = 1;
          held.dat = rsp_dat_o;
          held.err = rsp_err_o;
        end
      end
      if (cmd_valid_i && cmd_ready_o) busy = 1;
      if (rsp_valid_o && rsp_ready_i) busy = 0;
    end
  end

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      case (rdy_mode)
        0:       rsp_ready_i = 1'($urandom_range(0, 1));
        1:       rsp_ready_i = 1'b1;
        default: rsp_ready_i = 1'b0;
      endcase
    end
  end

  // Reference model: ack within TO cycles wins (reads return slave data,
  // writes return 0); otherwise an error response with zero data.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int d, input logic [31:0] rdata);
    cmd_t c;
    exp_t x;
    int   n;
    c = '{we: we, adr: adr, dat: dat, sel: sel, d: d, rdata: rdata};
    x.err = (d >= TO);
    x.dat = (x.err || we) ? 32'h0 : rdata;
    slv_q.push_back(c);
    exp_q.push_back(x);
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!cmd_ready_o && n < 300);
    chk("cmd_accept_timeout", 32'(cmd_ready_o), 32'd1);
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'($urandom_range(0, 1));
    cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wbm_cyc_o || rsp_valid_o) && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    chk({tag, "_rsp_dat"}, rsp_dat_o, 32'h0);
    chk({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(wbm_stb_o), 32'd0);
    chk({tag, "_we"}, 32'(wbm_we_o), 32'd0);
    chk({tag, "_adr"}, wbm_adr_o, 32'h0);
    chk({tag, "_dat"}, wbm_dat_o, 32'h0);
    chk({tag, "_sel"}, 32'(wbm_sel_o), 32'd0);
  endtask

  initial begin
    int n;
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_adr_i = 32'h0; cmd_dat_i = 32'h0; cmd_sel_i = 4'h0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk_idle_reset("reset");

    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hA5A5_A5A5);
    drain();
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 5, 32'h1234_5678);
    drain();

    stray_en = 1;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'h3, 50, 32'h5555_AAAA);
    drain();
    repeat (5) @(negedge wb_clk_i);
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, TO - 1, 32'hCAFE_F00D);
    drain();
    issue(1'b0, 32'h3000_0028, 32'h0, 4'hF, TO, 32'hBAD0_BAD0);
    drain();

    // Response backpressure with the next command held pending.
    rdy_mode = 2;
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hC, 2, 32'h0BAD_CAFE);
    fork
      issue(1'b1, 32'h3000_0034, 32'h7777_1111, 4'h1, 1, 32'h0);
    join_none
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid_o), 32'd1);
    repeat (10) @(negedge wb_clk_i);
    rdy_mode = 1;
    wait fork;
    drain();

    // Reset while a cycle is on the bus.
    stray_en = 0;
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF, 50, 32'h1111_2222);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk_idle_reset("midrst");
    repeat (4) @(negedge wb_clk_i);
    chk("midrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    issue(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h3333_4444);
    drain();

    rdy_mode = 0;
    stray_en = 1;
    repeat (40) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
            int'($urandom_range(0, 10)), $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
